// File: rtl/sc_insn_list_reader.sv
// Byte-stream reader for the serialized insn_info list: splits the stream into records and unpacks the len/ins/ext/typ fields.
// Optional feature macro SC_LSTRD_DIS_EN adds insn_dis with the first 16 bytes of the disassembly text.
module sc_insn_list_reader #(
  parameter int unsigned INFO_SIZE = 82,
  parameter int unsigned LEN_OFF   = 0,
  parameter int unsigned LEN_SIZE  = 8,
  parameter int unsigned INS_OFF   = 8,
  parameter int unsigned INS_SIZE  = 8,
  parameter int unsigned EXT_OFF   = 16,
  parameter int unsigned TYP_OFF   = 17,
  parameter int unsigned DIS_OFF   = 18,
  parameter int unsigned LIST_CAP  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        list_vld,
  input  logic [4:0]  list_cnt,
  output logic        list_err,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [7:0]  in_data,
  output logic        insn_vld,
  input  logic        insn_rdy,
  output logic [63:0] insn_len,
  output logic [63:0] insn_ins,
  output logic [7:0]  insn_ext,
  output logic [7:0]  insn_typ,
  output logic [3:0]  insn_idx,
  output logic        insn_last,
  output logic        list_done
`ifdef SC_LSTRD_DIS_EN
  ,
  output logic [127:0] insn_dis
`endif
);

  localparam logic [6:0] LAST_B = 7'(INFO_SIZE - 1);
  localparam logic [6:0] LEN_LO = 7'(LEN_OFF);
  localparam logic [6:0] LEN_SZ = 7'(LEN_SIZE);
  localparam logic [6:0] INS_LO = 7'(INS_OFF);
  localparam logic [6:0] INS_SZ = 7'(INS_SIZE);
  localparam logic [6:0] EXT_B  = 7'(EXT_OFF);
  localparam logic [6:0] TYP_B  = 7'(TYP_OFF);
  localparam logic [6:0] DIS_LO = 7'(DIS_OFF);
  localparam logic [4:0] CAP    = 5'(LIST_CAP);

  typedef enum logic [1:0] {IDLE, RECV, EMIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  byte_cnt;
  logic [3:0]  rec_idx;
  logic [4:0]  cnt;
  logic [63:0] len_q, ins_q;
  logic [7:0]  ext_q, typ_q;

  logic        acc, hs, last_rec, hdr;
  logic [6:0]  len_rel, ins_rel;

  assign acc      = (state == RECV) && in_vld;
  assign hs       = (state == EMIT) && insn_rdy;
  assign last_rec = ({1'b0, rec_idx} == (cnt - 5'd1));
  // Only the header region ahead of the disassembly text feeds the fixed fields.
  assign hdr      = (byte_cnt < DIS_LO);
  assign len_rel  = byte_cnt - LEN_LO;
  assign ins_rel  = byte_cnt - INS_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (list_vld) state_nxt = (list_cnt == 5'd0) ? DONE : RECV;
      RECV: if (acc && (byte_cnt == LAST_B)) state_nxt = EMIT;
      EMIT: if (insn_rdy) state_nxt = last_rec ? DONE : RECV;
      DONE: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the field registers are reset too because they drive ports that must read 0 out of reset.
      byte_cnt  <= '0;
      rec_idx   <= '0;
      cnt       <= '0;
      len_q     <= '0;
      ins_q     <= '0;
      ext_q     <= '0;
      typ_q     <= '0;
      list_err  <= 1'b0;
      list_done <= 1'b0;
    end else begin
      list_err  <= list_vld && ((state != IDLE) || (list_cnt > CAP));
      list_done <= (state == DONE);

      if ((state == IDLE) && list_vld) begin
        cnt      <= (list_cnt > CAP) ? CAP : list_cnt;
        rec_idx  <= '0;
        byte_cnt <= '0;
      end

      if (acc) begin
        byte_cnt <= (byte_cnt == LAST_B) ? 7'd0 : byte_cnt + 7'd1;
        if (hdr && (len_rel < LEN_SZ)) len_q[{len_rel[2:0], 3'b000} +: 8] <= in_data;
        if (hdr && (ins_rel < INS_SZ)) ins_q[{ins_rel[2:0], 3'b000} +: 8] <= in_data;
        if (hdr && (byte_cnt == EXT_B)) ext_q <= in_data;
        if (hdr && (byte_cnt == TYP_B)) typ_q <= in_data;
      end

      if (hs && !last_rec) begin
        rec_idx  <= rec_idx + 4'd1;
        byte_cnt <= '0;
      end
    end
  end

`ifdef SC_LSTRD_DIS_EN
  logic [6:0]   dis_rel;
  logic [127:0] dis_q;

  assign dis_rel = byte_cnt - DIS_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dis_q <= '0;
    else if (acc && (dis_rel < 7'd16)) dis_q[{dis_rel[3:0], 3'b000} +: 8] <= in_data;
  end

  assign insn_dis = dis_q;
`endif

  assign in_rdy    = (state == RECV);
  assign insn_vld  = (state == EMIT);
  assign insn_last = (state == EMIT) && last_rec;
  assign insn_idx  = rec_idx;
  assign insn_len  = len_q;
  assign insn_ins  = ins_q;
  assign insn_ext  = ext_q;
  assign insn_typ  = typ_q;

endmodule

// File: tb/tb_sc_insn_list_reader.sv
// Self-checking bench for sc_insn_list_reader: record table, stream driver and a scoreboard popped on each output handshake.
`timescale 1ns/1ps
module tb_sc_insn_list_reader;

  localparam int INFO = 82;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        list_vld = 1'b0;
  logic [4:0]  list_cnt = '0;
  logic        list_err;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_data = '0;
  logic        insn_vld;
  logic        insn_rdy = 1'b0;
  logic [63:0] insn_len, insn_ins;
  logic [7:0]  insn_ext, insn_typ;
  logic [3:0]  insn_idx;
  logic        insn_last;
  logic        list_done;
`ifdef SC_LSTRD_DIS_EN
  logic [127:0] insn_dis;
`endif

  always #5 clk = ~clk;

  sc_insn_list_reader dut (
    .clk(clk), .rst(rst),
    .list_vld(list_vld), .list_cnt(list_cnt), .list_err(list_err),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .insn_vld(insn_vld), .insn_rdy(insn_rdy),
    .insn_len(insn_len), .insn_ins(insn_ins), .insn_ext(insn_ext), .insn_typ(insn_typ),
    .insn_idx(insn_idx), .insn_last(insn_last), .list_done(list_done)
`ifdef SC_LSTRD_DIS_EN
    , .insn_dis(insn_dis)
`endif
  );

  typedef struct packed {
    logic [63:0] len;
    logic [63:0] ins;
    logic [7:0]  ext;
    logic [7:0]  typ;
    logic [3:0]  idx;
    logic        last;
`ifdef SC_LSTRD_DIS_EN
    logic [127:0] dis;
`endif
  } exp_t;

  typedef struct {
    logic [63:0] len;
    logic [63:0] ins;
    logic [7:0]  ext;
    logic [7:0]  typ;
    logic [3:0]  exp_idx;
    logic        exp_last;
  } vec_t;

  exp_t sb[$];
  vec_t tab [16];
  logic [7:0] img [INFO];

  int n_pass = 0, n_checks = 0;
  int n_hs = 0, n_done = 0, n_err = 0, n_viol = 0;
  int rdy_mode = 0;  // 0: bench drives insn_rdy by hand, 1: always ready, 2: random stalls
  bit stalled = 1'b0;
  exp_t mon_a, mon_e;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: pulse counters plus scoreboard compare on every accepted record.
  always @(negedge clk) begin
    if (!rst) begin
      if (list_done) n_done++;
      if (list_err) n_err++;
      if (insn_vld && in_rdy) n_viol++;
      if (insn_vld && insn_rdy) begin
        n_hs++;
        if (sb.size() == 0) begin
          check("unexpected_record", 256'(insn_idx) + 256'd1, 256'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_a.len  = insn_len;
          mon_a.ins  = insn_ins;
          mon_a.ext  = insn_ext;
          mon_a.typ  = insn_typ;
          mon_a.idx  = insn_idx;
          mon_a.last = insn_last;
`ifdef SC_LSTRD_DIS_EN
          mon_a.dis  = insn_dis;
`endif
          check("record", 256'(mon_a), 256'(mon_e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) insn_rdy = 1'b1;
      else if (rdy_mode == 2) insn_rdy = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic build_img(input vec_t v);
    for (int k = 0; k < 8; k++) begin
      img[k]     = v.len[8*k +: 8];
      img[8 + k] = v.ins[8*k +: 8];
    end
    img[16] = v.ext;
    img[17] = v.typ;
    for (int k = 18; k < INFO; k++) img[k] = 8'($urandom);
  endtask

  task automatic push_exp(input vec_t v, input logic [3:0] idx, input logic last);
    exp_t e;
    e.len  = v.len;
    e.ins  = v.ins;
    e.ext  = v.ext;
    e.typ  = v.typ;
    e.idx  = idx;
    e.last = last;
`ifdef SC_LSTRD_DIS_EN
    for (int k = 0; k < 16; k++) e.dis[8*k +: 8] = img[18 + k];
`endif
    sb.push_back(e);
  endtask

  // Entered and left at posedge+1; list_vld may ride along with the byte.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int n;
    if (stalled) return;
    for (int g = 0; g < gap; g++) begin
      in_vld = 1'b0;
      @(posedge clk); #1;
    end
    in_vld   = 1'b1;
    in_data  = b;
    list_vld = pulse;
    if (pulse) list_cnt = 5'd2;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 300) begin
        check("byte_timeout", 256'(n), 256'd0);
        stalled = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_vld   = 1'b0;
    list_vld = 1'b0;
  endtask

  task automatic send_rec(input int nbytes, input int gapmax, input int pulse_at);
    for (int i = 0; i < nbytes; i++)
      send_byte(img[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, i == pulse_at);
  endtask

  task automatic start_list(input logic [4:0] c);
    list_cnt = c;
    list_vld = 1'b1;
    @(posedge clk); #1;
    list_vld = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = n_done;
    int n = 0;
    while ((n_done == d0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 256'(n_done - d0), 256'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, e0, d0;
    vec_t v;

    tab[0] = '{len: 64'd4, ins: 64'h0000_0013, ext: 8'h01, typ: 8'h02, exp_idx: 4'd0, exp_last: 1'b0};
    tab[1] = '{len: 64'hFFFF_FFFF_FFFF_FFFF, ins: 64'h8000_0000_0000_0001, ext: 8'hFF, typ: 8'h00, exp_idx: 4'd1, exp_last: 1'b0};
    tab[2] = '{len: 64'h0102_0304_0506_0708, ins: 64'hA1B2_C3D4_E5F6_0718, ext: 8'h5A, typ: 8'hA5, exp_idx: 4'd2, exp_last: 1'b0};
    for (int i = 3; i < 16; i++) begin
      tab[i].len      = 64'($urandom_range(1, 15));
      tab[i].ins      = {$urandom, $urandom};
      tab[i].ext      = 8'($urandom);
      tab[i].typ      = 8'($urandom);
      tab[i].exp_idx  = 4'(i);
      tab[i].exp_last = (i == 15);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 256'({insn_vld, in_rdy, list_err, list_done, insn_last, insn_idx,
                               insn_len, insn_ins, insn_ext, insn_typ}), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_rdy", 256'(in_rdy), 256'd0);

    // Single record, held by downstream for a few cycles
    rdy_mode = 0;
    insn_rdy = 1'b0;
    v = '{len: 64'd4, ins: 64'h13, ext: 8'h01, typ: 8'h02, exp_idx: 4'd0, exp_last: 1'b1};
    build_img(v);
    push_exp(v, 4'd0, 1'b1);
    start_list(5'd1);
    send_rec(INFO, 0, -1);
    check("latency_vld", 256'(insn_vld), 256'd1);
    check("emit_in_rdy", 256'(in_rdy), 256'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_fields", 256'({insn_vld, insn_last, insn_idx, insn_len, insn_ins, insn_ext, insn_typ}),
          256'({1'b1, 1'b1, 4'd0, 64'd4, 64'h13, 8'd1, 8'd2}));
    insn_rdy = 1'b1;
    @(posedge clk); #1;
    insn_rdy = 1'b0;
    check("single_hs", 256'(n_hs), 256'd1);
    wait_done("single_done", 10);

    // Full list of 16 with input gaps and downstream stalls
    rdy_mode = 2;
    h0 = n_hs;
    n_viol = 0;
    start_list(5'd16);
    for (int i = 0; i < 16; i++) begin
      build_img(tab[i]);
      push_exp(tab[i], tab[i].exp_idx, tab[i].exp_last);
      send_rec(INFO, 2, -1);
    end
    wait_done("full_done", 400);
    check("full_hs", 256'(n_hs - h0), 256'd16);
    check("full_no_rdy_in_emit", 256'(n_viol), 256'd0);
    check("full_sb_empty", 256'(sb.size()), 256'd0);

    // Empty list: list_done two cycles after list_vld, no stream ready
    rdy_mode = 1;
    start_list(5'd0);
    check("empty_c1", 256'({list_done, in_rdy}), 256'd0);
    @(posedge clk); #1;
    check("empty_c2", 256'({list_done, in_rdy}), 256'b10);
    @(posedge clk); #1;
    check("empty_c3", 256'({list_done, in_rdy}), 256'd0);

    // Over-capacity count clamps to 16 and flags an error
    h0 = n_hs;
    e0 = n_err;
    start_list(5'd20);
    check("clamp_err_pulse", 256'(list_err), 256'd1);
    for (int i = 0; i < 16; i++) begin
      build_img(tab[i]);
      push_exp(tab[i], tab[i].exp_idx, tab[i].exp_last);
      send_rec(INFO, 1, -1);
    end
    wait_done("clamp_done", 400);
    check("clamp_hs", 256'(n_hs - h0), 256'd16);
    check("clamp_err_count", 256'(n_err - e0), 256'd1);
    check("clamp_idle", 256'(in_rdy), 256'd0);

    // list_vld during record 3 is rejected without disturbing the list
    h0 = n_hs;
    e0 = n_err;
    start_list(5'd5);
    for (int i = 0; i < 5; i++) begin
      build_img(tab[i]);
      push_exp(tab[i], 4'(i), i == 4);
      send_rec(INFO, 0, (i == 3) ? 40 : -1);
    end
    wait_done("busy_done", 100);
    check("busy_err_count", 256'(n_err - e0), 256'd1);
    check("busy_hs", 256'(n_hs - h0), 256'd5);

    // Asynchronous reset in the middle of record 2
    start_list(5'd3);
    for (int i = 0; i < 2; i++) begin
      build_img(tab[8 + i]);
      push_exp(tab[8 + i], 4'(i), 1'b0);
      send_rec(INFO, 0, -1);
    end
    build_img(tab[10]);
    send_rec(30, 0, -1);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    check("rst_async", 256'({insn_vld, in_rdy, list_err, list_done, insn_last, insn_idx,
                             insn_len, insn_ins, insn_ext, insn_typ}), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", 256'(n_done - d0), 256'd0);
    check("rst_sb_empty", 256'(sb.size()), 256'd0);
    check("rst_idle", 256'({in_rdy, insn_vld}), 256'd0);

    h0 = n_hs;
    v = '{len: 64'd2, ins: 64'h0000_0000_DEAD_BEEF, ext: 8'h07, typ: 8'h3C, exp_idx: 4'd0, exp_last: 1'b1};
    build_img(v);
    push_exp(v, 4'd0, 1'b1);
    start_list(5'd1);
    send_rec(INFO, 1, -1);
    wait_done("post_rst_done", 20);
    check("post_rst_hs", 256'(n_hs - h0), 256'd1);
    check("post_rst_sb_empty", 256'(sb.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
